// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / load-store RAM arbiter:
// bus widths, byte-select width, FSM state and grant encodings.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned SEL_WIDTH  = 4;

  localparam logic [SEL_WIDTH-1:0] SEL_WORD = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_IF  = 2'd1,
    SERVE_MEM = 2'd2
  } state_e;

  // One-hot grant: bit 0 is the fetch port, bit 1 the load/store port.
  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_IF   = 2'b01,
    GNT_MEM  = 2'b10
  } grant_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle around the arbiter: fetch port, load/store port and shared RAM port.
// master = requesters plus RAM, slave = arbiter.
interface mem_arbiter_if #(
  parameter int unsigned AddrWidth = mem_arbiter_pkg::ADDR_WIDTH,
  parameter int unsigned DataWidth = mem_arbiter_pkg::DATA_WIDTH
);
  import mem_arbiter_pkg::*;

  logic                 if_re;
  logic [AddrWidth-1:0] if_addr;
  logic                 if_busy;
  logic                 if_done;
  logic [DataWidth-1:0] if_data;

  logic                 mem_re;
  logic                 mem_we;
  logic [AddrWidth-1:0] mem_addr;
  logic [DataWidth-1:0] mem_wdata;
  logic [SEL_WIDTH-1:0] mem_sel;
  logic                 mem_busy;
  logic                 mem_done;
  logic [DataWidth-1:0] mem_data;

  logic                 ram_req;
  logic                 ram_we;
  logic [AddrWidth-1:0] ram_addr;
  logic [DataWidth-1:0] ram_wdata;
  logic [SEL_WIDTH-1:0] ram_sel;
  logic                 ram_ack;
  logic [DataWidth-1:0] ram_rdata;

  modport master (
    output if_re, if_addr, mem_re, mem_we, mem_addr, mem_wdata, mem_sel,
           ram_ack, ram_rdata,
    input  if_busy, if_done, if_data, mem_busy, mem_done, mem_data,
           ram_req, ram_we, ram_addr, ram_wdata, ram_sel
  );

  modport slave (
    input  if_re, if_addr, mem_re, mem_we, mem_addr, mem_wdata, mem_sel,
           ram_ack, ram_rdata,
    output if_busy, if_done, if_data, mem_busy, mem_done, mem_data,
           ram_req, ram_we, ram_addr, ram_wdata, ram_sel
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Fetch vs load/store grant selection. Load/store wins a tie unless it already
// won the last two grants while fetch was waiting.
module mem_arb_grant
  import mem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req_i,
  input  logic   mem_req_i,
  input  logic   take_i,
  output grant_e gnt_o
);

  // Consecutive load/store grants made while fetch was also requesting.
  logic [1:0] streak_q, streak_d;

  always_comb begin
    gnt_o = GNT_NONE;
    if (mem_req_i && !(if_req_i && streak_q == 2'd2)) begin
      gnt_o = GNT_MEM;
    end else if (if_req_i) begin
      gnt_o = GNT_IF;
    end
  end

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the signal unassigned (latch).
    streak_d = streak_q;
    if (take_i) begin
      streak_d = (gnt_o == GNT_MEM && if_req_i) ? streak_q + 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= 2'd0;
    end else begin
      // NOTE: non-blocking so every flop updates from pre-edge values.
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port RAM arbiter: one outstanding transaction on a shared RAM port,
// serving instruction fetch reads and load/store accesses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AddrWidth = ADDR_WIDTH,
  parameter int unsigned DataWidth = DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 if_re_i,
  input  logic [AddrWidth-1:0] if_addr_i,
  output logic                 if_busy_o,
  output logic                 if_done_o,
  output logic [DataWidth-1:0] if_data_o,

  input  logic                 mem_re_i,
  input  logic                 mem_we_i,
  input  logic [AddrWidth-1:0] mem_addr_i,
  input  logic [DataWidth-1:0] mem_wdata_i,
  input  logic [SEL_WIDTH-1:0] mem_sel_i,
  output logic                 mem_busy_o,
  output logic                 mem_done_o,
  output logic [DataWidth-1:0] mem_data_o,

  output logic                 ram_req_o,
  output logic                 ram_we_o,
  output logic [AddrWidth-1:0] ram_addr_o,
  output logic [DataWidth-1:0] ram_wdata_o,
  output logic [SEL_WIDTH-1:0] ram_sel_o,
  input  logic                 ram_ack_i,
  input  logic [DataWidth-1:0] ram_data_i
);

  state_e               state_q, state_d;
  logic                 ram_req_q, ram_req_d;
  logic                 ram_we_q, ram_we_d;
  logic [AddrWidth-1:0] ram_addr_q, ram_addr_d;
  logic [DataWidth-1:0] ram_wdata_q, ram_wdata_d;
  logic [SEL_WIDTH-1:0] ram_sel_q, ram_sel_d;
  logic                 if_done_q, if_done_d;
  logic                 mem_done_q, mem_done_d;
  logic [DataWidth-1:0] if_data_q, if_data_d;
  logic [DataWidth-1:0] mem_data_q, mem_data_d;

  logic   mem_req;
  logic   take;
  grant_e gnt;

  assign mem_req = mem_re_i | mem_we_i;
  // The done cycle is a bubble: nothing is accepted while a done pulse is high.
  assign take = (state_q == IDLE) && !if_done_q && !mem_done_q && (if_re_i || mem_req);

  mem_arb_grant u_grant (
    .clk       (clk),
    .rst       (rst),
    .if_req_i  (if_re_i),
    .mem_req_i (mem_req),
    .take_i    (take),
    .gnt_o     (gnt)
  );

  always_comb begin
    state_d     = state_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_sel_d   = ram_sel_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_data_d  = mem_data_q;

    unique case (state_q)
      IDLE: begin
        if (take) begin
          ram_req_d = 1'b1;
          if (gnt == GNT_MEM) begin
            state_d     = SERVE_MEM;
            ram_we_d    = mem_we_i;  // read+write together counts as a write
            ram_addr_d  = mem_addr_i;
            ram_wdata_d = mem_wdata_i;
            ram_sel_d   = mem_sel_i;
          end else begin
            state_d     = SERVE_IF;
            ram_we_d    = 1'b0;
            ram_addr_d  = if_addr_i;
            ram_wdata_d = '0;
            ram_sel_d   = SEL_WORD;
          end
        end
      end
      SERVE_IF, SERVE_MEM: begin
        if (ram_ack_i) begin
          state_d     = IDLE;
          ram_req_d   = 1'b0;
          ram_we_d    = 1'b0;
          ram_addr_d  = '0;
          ram_wdata_d = '0;
          ram_sel_d   = '0;
          if (state_q == SERVE_IF) begin
            if_done_d = 1'b1;
            if_data_d = ram_data_i;
          end else begin
            mem_done_d = 1'b1;
            if (!ram_we_q) mem_data_d = ram_data_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_sel_q   <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_sel_q   <= ram_sel_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign if_busy_o   = (state_q != IDLE);
  assign mem_busy_o  = (state_q != IDLE);
  assign if_done_o   = if_done_q;
  assign mem_done_o  = mem_done_q;
  assign if_data_o   = if_data_q;
  assign mem_data_o  = mem_data_q;
  assign ram_req_o   = ram_req_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign ram_sel_o   = ram_sel_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AddrWidth(32), .DataWidth(32)) bus ();

  mem_arbiter #(.AddrWidth(32), .DataWidth(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_re_i     (bus.if_re),
    .if_addr_i   (bus.if_addr),
    .if_busy_o   (bus.if_busy),
    .if_done_o   (bus.if_done),
    .if_data_o   (bus.if_data),
    .mem_re_i    (bus.mem_re),
    .mem_we_i    (bus.mem_we),
    .mem_addr_i  (bus.mem_addr),
    .mem_wdata_i (bus.mem_wdata),
    .mem_sel_i   (bus.mem_sel),
    .mem_busy_o  (bus.mem_busy),
    .mem_done_o  (bus.mem_done),
    .mem_data_o  (bus.mem_data),
    .ram_req_o   (bus.ram_req),
    .ram_we_o    (bus.ram_we),
    .ram_addr_o  (bus.ram_addr),
    .ram_wdata_o (bus.ram_wdata),
    .ram_sel_o   (bus.ram_sel),
    .ram_ack_i   (bus.ram_ack),
    .ram_data_i  (bus.ram_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct packed {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } txn_t;

  typedef struct packed {
    logic is_mem;
    logic if_pending;
  } grant_rec_t;

  txn_t        m_txn;
  grant_rec_t  hist[$];
  bit          m_active   = 1'b0;
  bit          m_if_done  = 1'b0;
  bit          m_mem_done = 1'b0;
  logic [31:0] m_if_data  = '0;
  logic [31:0] m_mem_data = '0;
  bit          prev_done, want_mem, pick_mem;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_active   = 1'b0;
      m_if_done  = 1'b0;
      m_mem_done = 1'b0;
      m_if_data  = '0;
      m_mem_data = '0;
      m_txn      = '0;
      hist.delete();
    end else begin
      prev_done  = m_if_done || m_mem_done;
      m_if_done  = 1'b0;
      m_mem_done = 1'b0;
      want_mem   = bus.mem_re || bus.mem_we;
      if (m_active) begin
        if (bus.ram_ack) begin
          if (m_txn.is_mem) begin
            m_mem_done = 1'b1;
            if (!m_txn.we) m_mem_data = bus.ram_rdata;
          end else begin
            m_if_done = 1'b1;
            m_if_data = bus.ram_rdata;
          end
          m_active = 1'b0;
        end
      end else if (!prev_done && (bus.if_re || want_mem)) begin
        pick_mem = want_mem;
        if (want_mem && bus.if_re && hist.size() >= 2 &&
            hist[hist.size()-1].is_mem && hist[hist.size()-1].if_pending &&
            hist[hist.size()-2].is_mem && hist[hist.size()-2].if_pending)
          pick_mem = 1'b0;
        hist.push_back('{is_mem: pick_mem, if_pending: bus.if_re});
        if (hist.size() > 2) void'(hist.pop_front());
        if (pick_mem)
          m_txn = '{is_mem: 1'b1, we: bus.mem_we, addr: bus.mem_addr,
                    wdata: bus.mem_wdata, sel: bus.mem_sel};
        else
          m_txn = '{is_mem: 1'b0, we: 1'b0, addr: bus.if_addr,
                    wdata: 32'h0, sel: 4'hF};
        m_active = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("if_busy",  bus.if_busy,  m_active);
    check("mem_busy", bus.mem_busy, m_active);
    check("if_done",  bus.if_done,  m_if_done);
    check("mem_done", bus.mem_done, m_mem_done);
    check("if_data",  bus.if_data,  m_if_data);
    check("mem_data", bus.mem_data, m_mem_data);
    check("ram_req",  bus.ram_req,  m_active);
    if (m_active) begin
      check("ram_we",   bus.ram_we,   m_txn.we);
      check("ram_addr", bus.ram_addr, m_txn.addr);
      check("ram_sel",  bus.ram_sel,  m_txn.sel);
      if (m_txn.we) check("ram_wdata", bus.ram_wdata, m_txn.wdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack(input logic [31:0] d);
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = d;
    tick();
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 20 && !bus.ram_req; i++) tick();
    if (!bus.ram_req) check({name, "_req_timeout"}, bus.ram_req, 1'b1);
  endtask

  bit exp_mem_seq [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    bus.if_re = 0; bus.if_addr = '0;
    bus.mem_re = 0; bus.mem_we = 0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_sel = '0;
    bus.ram_ack = 0; bus.ram_rdata = '0;

    #3 rst = 1'b0;
    tick(); tick();
    check("rst_busy",    bus.mem_busy, 0);
    check("rst_ram_req", bus.ram_req,  0);
    check("rst_if_data", bus.if_data,  0);

    // IF read right at reset release; ack two cycles after request rises.
    rst = 1'b1;
    bus.if_re = 1; bus.if_addr = 32'h0000_0100;
    tick();
    check("t1_req_first_edge", bus.ram_req,  1);
    check("t1_we",             bus.ram_we,   0);
    check("t1_sel",            bus.ram_sel,  4'hF);
    check("t1_addr",           bus.ram_addr, 32'h100);
    bus.if_re = 0;
    tick(); tick();
    ack(32'h0000_0013);
    check("t1_done",      bus.if_done, 1);
    check("t1_data",      bus.if_data, 32'h13);
    tick();
    check("t1_done_fall", bus.if_done, 0);

    // Simultaneous IF read and MEM write: MEM first, then IF.
    bus.if_re = 1; bus.if_addr = 32'h100;
    bus.mem_we = 1; bus.mem_addr = 32'h2000; bus.mem_wdata = 32'hDEAD_BEEF; bus.mem_sel = 4'b0011;
    tick();
    check("t2_we",    bus.ram_we,    1);
    check("t2_sel",   bus.ram_sel,   4'b0011);
    check("t2_addr",  bus.ram_addr,  32'h2000);
    check("t2_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
    bus.mem_we = 0;
    ack(32'h0);
    check("t2_mem_done",  bus.mem_done, 1);
    check("t2_if_wait",   bus.if_done,  0);
    tick();
    check("t2_no_accept_in_done", bus.ram_req, 0);
    tick();
    check("t2_if_req",  bus.ram_req,  1);
    check("t2_if_addr", bus.ram_addr, 32'h100);
    bus.if_re = 0;
    ack(32'h55);
    check("t2_if_done",   bus.if_done,  1);
    check("t2_if_data",   bus.if_data,  32'h55);
    check("t2_wr_no_data", bus.mem_data, 32'h0);
    tick();

    // Continuous MEM loads with IF pending: MEM, MEM, IF repeating.
    bus.if_re = 1; bus.if_addr = 32'h100;
    bus.mem_re = 1; bus.mem_addr = 32'h3000; bus.mem_sel = 4'hF;
    for (int g = 0; g < 6; g++) begin
      wait_req("t3");
      check($sformatf("t3_grant%0d_is_mem", g), bus.ram_addr == 32'h3000, exp_mem_seq[g]);
      ack(32'h1000 + g);
    end
    bus.if_re = 0; bus.mem_re = 0;
    tick(); tick();
    check("t3_if_data",  bus.if_data,  32'h1005);
    check("t3_mem_data", bus.mem_data, 32'h1004);

    // MEM read whose request drops right after acceptance still completes.
    bus.mem_re = 1; bus.mem_addr = 32'h40;
    tick();
    check("t4_req", bus.ram_req, 1);
    bus.mem_re = 0;
    tick();
    ack(32'hCAFE_F00D);
    check("t4_done", bus.mem_done, 1);
    check("t4_data", bus.mem_data, 32'hCAFE_F00D);
    tick();
    check("t4_done_fall", bus.mem_done, 0);

    // Spurious ack while idle.
    bus.ram_ack = 1; bus.ram_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    bus.ram_ack = 0; bus.ram_rdata = '0;
    check("t5_no_if_done",  bus.if_done,  0);
    check("t5_no_mem_done", bus.mem_done, 0);
    check("t5_mem_data",    bus.mem_data, 32'hCAFE_F00D);
    check("t5_if_data",     bus.if_data,  32'h1005);
    tick();

    // Reset during SERVE_MEM; late ack after release is dropped.
    bus.mem_re = 1; bus.mem_addr = 32'h80;
    tick();
    check("t6_busy", bus.mem_busy, 1);
    bus.mem_re = 0;
    tick();
    rst = 1'b0;
    #1;
    check("t6_rst_busy",    bus.mem_busy, 0);
    check("t6_rst_req",     bus.ram_req,  0);
    check("t6_rst_memdata", bus.mem_data, 0);
    tick();
    rst = 1'b1;
    ack(32'h77);
    check("t6_no_done", bus.mem_done, 0);
    check("t6_data",    bus.mem_data, 0);
    check("t6_idle",    bus.mem_busy, 0);
    tick();
    check("t6_no_done_late", bus.mem_done, 0);

    // Normal IF read after the aborted transaction.
    bus.if_re = 1; bus.if_addr = 32'h200;
    tick();
    check("t7_req", bus.ram_req, 1);
    bus.if_re = 0;
    ack(32'hABCD);
    check("t7_done", bus.if_done, 1);
    check("t7_data", bus.if_data, 32'hABCD);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, RAM byte-address width.
REQ-002 SHALL have parameter DataWidth, default 32, RAM data width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports if_re_i input 1, if_addr_i input AddrWidth: fetch read request and address.
REQ-006 SHALL have ports if_busy_o output 1, if_done_o output 1, if_data_o output DataWidth: fetch handshake and read data.
REQ-007 SHALL have ports mem_re_i input 1, mem_we_i input 1, mem_addr_i input AddrWidth, mem_wdata_i input DataWidth, mem_sel_i input 4: load/store request, byte enables.
REQ-008 SHALL have ports mem_busy_o output 1, mem_done_o output 1, mem_data_o output DataWidth: load/store handshake and load data.
REQ-009 SHALL have ports ram_req_o output 1, ram_we_o output 1, ram_addr_o output AddrWidth, ram_wdata_o output DataWidth, ram_sel_o output 4: single shared RAM port.
REQ-010 SHALL have ports ram_ack_i input 1, ram_data_i input DataWidth: RAM completion pulse and read data.

Function
REQ-011 SHALL implement states IDLE, SERVE_IF, SERVE_MEM; one RAM transaction outstanding at most.
REQ-012 In IDLE, a request (if_re_i, or mem_re_i|mem_we_i) sampled at a clock edge SHALL be accepted and its address/data/sel/we captured in registers; state moves to SERVE_IF or SERVE_MEM.
REQ-013 Simultaneous IF and MEM requests in IDLE SHALL grant MEM, unless MEM was granted on each of the last two grants while IF was pending, then IF.
REQ-014 mem_re_i and mem_we_i both high SHALL be treated as a write.
REQ-015 ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_sel_o SHALL be registered, driven from the captured values from the cycle after acceptance until the cycle ram_ack_i is sampled high, inclusive.
REQ-016 For IF transactions, ram_we_o SHALL be 0 and ram_sel_o SHALL be 4'b1111.
REQ-017 On ram_ack_i high in SERVE_x, ram_data_i SHALL be latched into x_data_o (reads only), x_done_o SHALL pulse high for exactly the next cycle, and state SHALL return to IDLE.
REQ-018 x_data_o SHALL hold its value until the next completed read on that port; writes SHALL not modify mem_data_o.
REQ-019 x_busy_o SHALL be high whenever state is not IDLE, low in IDLE; requesters issue only when busy is low.
REQ-020 A request SHALL not be accepted in the cycle a done pulse is asserted; minimum accept-to-accept spacing is 3 cycles (ack on first request cycle).
REQ-021 Request deassertion after acceptance SHALL NOT cancel the transaction; done still pulses.
REQ-022 ram_ack_i sampled high in IDLE SHALL be ignored; no done pulse, no data update.
REQ-023 No timeout; arbiter SHALL wait indefinitely for ram_ack_i.

Reset
REQ-024 On rst low, state SHALL become IDLE and every output, captured register and fairness counter SHALL be zero, asynchronously.
REQ-025 Reset during SERVE_x SHALL abort the transaction: no done pulse; a late ram_ack_i after reset release is dropped per REQ-022.
REQ-026 Release SHALL be synchronous-deasserted by the system; first request SHALL be accepted at the first edge after release.

Structure
REQ-027 State encodings and the 4-bit byte-select width SHALL live in the shared define package alongside existing width macros.
REQ-028 Grant/fairness logic SHALL be a sub-module mem_arb_grant (two request inputs, last-grant history, one-hot grant out); remainder is a single FSM.

Verification
REQ-029 IF read 0x0000_0100, ack 2 cycles after ram_req_o rises with data 0x0000_0013 -> if_done_o one-cycle pulse, if_data_o=0x0000_0013, ram_we_o=0.
REQ-030 Same-edge IF read 0x100 and MEM write 0x2000/0xDEADBEEF/sel 4'b0011 -> MEM served first (ram_we_o=1, sel 0011), IF served after, both done pulses in that order.
REQ-031 Continuous MEM loads with IF pending -> grant sequence MEM, MEM, IF, repeating.
REQ-032 rst low while SERVE_MEM, ack arrives after release -> no mem_done_o, mem_data_o=0, state IDLE.
REQ-033 MEM read accepted then mem_re_i dropped next cycle, ack data 0xCAFE_F00D -> mem_done_o pulses, mem_data_o=0xCAFE_F00D.
REQ-034 Spurious ram_ack_i in IDLE -> no done pulses, data outputs unchanged.
